// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding, quarter-phase and bit-count constants for the SCCB write master.
package sccb_pkg;
  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, DONE} state_t;
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;
  localparam int BITS_PER_BYTE = 9;
  localparam int TOTAL_BITS = 27;
  localparam int START_Q = 2;
  localparam int STOP_Q = 3;
  function automatic logic is_ack_bit(input logic [4:0] b);
    return (b == 5'(BITS_PER_BYTE - 1)) || (b == 5'(2 * BITS_PER_BYTE - 1)) || (b == 5'(TOTAL_BITS - 1));
  endfunction
endpackage

// File: rtl/sccb_write_master_if.sv
// sccb_write_master_if: request/response handshake between the config sequencer and the SCCB write master.
interface sccb_write_master_if;
  logic [23:0] iDATA;
  logic iGO;
  logic oEND;
  logic oACK;
  logic oBUSY;
  modport master(output iDATA, iGO, input oEND, oACK, oBUSY);
  modport slave(input iDATA, iGO, output oEND, oACK, oBUSY);
endinterface

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: one-cycle quarter-period tick every Q clocks, with synchronous restart.
module sccb_tick_gen #(
  parameter int Q = 125
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic restart,
  output logic tick
);
  localparam int W = (Q > 1) ? $clog2(Q) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(Q - 1);
    cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sccb_write_master.sv
// sccb_write_master: 3-byte SCCB/I2C register write master; define SCCB_ACK_CHECK_EN to sample slave ACKs into oACK.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  sccb_write_master_if.slave  req,
  output logic                I2C_SCLK,
  inout  wire                 I2C_SDAT
);
  localparam int Q = CLK_FREQ / (4 * SCL_FREQ);
  if (Q < 2) begin : g_bad_q
    $error("sccb_write_master: quarter period Q must be at least 2");
  end
  state_t state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [4:0] bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic tick, restart, ack_bit, sda_low;
`ifdef SCCB_ACK_CHECK_EN
  logic nack_q, nack_d;
`endif
  sccb_tick_gen #(.Q(Q)) u_tick (.iCLK, .iRST_N, .restart, .tick);
  assign ack_bit = is_ack_bit(bit_q);
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    bit_d = bit_q;
    sh_d = sh_q;
    restart = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    nack_d = nack_q;
`endif
    case (state_q)
      IDLE: if (req.iGO) begin
        state_d = START;
        ph_d = PH0;
        bit_d = '0;
        sh_d = req.iDATA;
        restart = 1'b1;
`ifdef SCCB_ACK_CHECK_EN
        nack_d = 1'b0;
`endif
      end
      START: if (tick) begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'(START_Q - 1)) begin
          state_d = SHIFT;
          ph_d = PH0;
        end
      end
      SHIFT: if (tick) begin
        ph_d = ph_q + 2'd1;
`ifdef SCCB_ACK_CHECK_EN
        // the PH1 tick is the start of q2: SCL has been high for a full quarter
        if (ph_q == PH1 && ack_bit && I2C_SDAT) nack_d = 1'b1;
`endif
        if (ph_q == PH3) begin
          if (!ack_bit) sh_d = {sh_q[22:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'(TOTAL_BITS - 1)) begin
            state_d = STOP;
            bit_d = '0;
          end
        end
      end
      STOP: if (tick) begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'(STOP_Q - 1)) begin
          state_d = DONE;
          ph_d = PH0;
        end
      end
      DONE: if (!req.iGO) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q <= IDLE;
      ph_q <= PH0;
      bit_q <= '0;
      sh_q <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
`ifdef SCCB_ACK_CHECK_EN
      nack_q <= nack_d;
`endif
    end
  // pins decode straight from registered state so reset releases the bus immediately
  always_comb begin
    I2C_SCLK = state_q == SHIFT ? (ph_q == PH1 || ph_q == PH2) :
               state_q == STOP  ? ph_q != PH0 : 1'b1;
    sda_low = state_q == START ? ph_q == PH1 :
              state_q == SHIFT ? (!ack_bit && !sh_q[23]) :
              state_q == STOP  ? ph_q != PH2 : 1'b0;
    req.oBUSY = state_q == START || state_q == SHIFT || state_q == STOP;
    req.oEND = state_q == DONE;
`ifdef SCCB_ACK_CHECK_EN
    req.oACK = state_q == DONE && nack_q;
`else
    req.oACK = 1'b0;
`endif
  end
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
endmodule
